grf: RTL
========

# grf

General register file for the single-cycle MIPS datapath: the consumer of the write-back path that selects the destination register (rt/rd/$31) and write data (ALU result, memory data, or PC+4). Holds 31 writable 32-bit registers plus hardwired $0, exposes two combinational read ports for the decode stage, and emits a one-cycle registered write-trace record per accepted write for the course checker. Sits between the write-back selection logic and the ALU operand selection.

## Interface

- DATA_W, 32, register width
- ADDR_W, 5, register index width (2^ADDR_W registers, index 0 hardwired)
- BYPASS, 1, 1 = read ports return same-cycle write data on address match; 0 = read returns stored value only

- clk  in  1  single clock, all state updates on rising edge
- reset  in  1  asynchronous, active-low; asserted (0) clears all state immediately
- we  in  1  register write enable (RegWrite)
- wa  in  ADDR_W  write address (RegAddr from write-back selection)
- wd  in  DATA_W  write data (RegData from write-back selection)
- wpc  in  32  PC of the instruction performing the write (trace only)
- ra1  in  ADDR_W  read address 1 (rs)
- ra2  in  ADDR_W  read address 2 (rt)
- rd1  out  DATA_W  read data 1
- rd2  out  DATA_W  read data 2
- trace_valid  out  1  one-cycle pulse: a write was accepted on the previous edge
- trace_pc  out  32  PC of traced write
- trace_addr  out  ADDR_W  register index of traced write
- trace_data  out  DATA_W  value of traced write

## Operation

- Reset (reset=0, asynchronous): registers 1..31 -> 0; trace_valid, trace_pc, trace_addr, trace_data -> 0. Reads during reset return 0 for every address (bypass suppressed).
- Write: at rising clk with reset=1 and we=1 and wa!=0: reg[wa] <= wd.
- we=1, wa=0: no register changes; $0 stays 0.
- Read: rdN = 0 if raN==0; else if BYPASS=1 and we=1 and wa==raN: wd; else reg[raN]. Purely combinational.
- Both read ports may address the same register or the write register simultaneously; each resolves independently by the rule above.
- Trace: at rising clk with reset=1: trace_valid <= we; if we=1, trace_pc <= wpc, trace_addr <= wa, trace_data <= (wa==0 ? 0 : wd). Trace fields hold last value when trace_valid=0.
- Writes to $0 with we=1 still produce a trace record (data reported as 0) so the checker sees every write-enabled instruction.
- No X propagation: unknown we treated as illegal; verification asserts we is never X after reset release.

## Timing

- Read latency: 0 cycles (combinational from raN, and from we/wa/wd when BYPASS=1).
- Write latency: 1 edge; value visible via stored path on the cycle after the edge, via bypass on the same cycle.
- Trace latency: 1 cycle after the accepting edge; trace_valid high for exactly one cycle per write-enabled cycle; back-to-back writes give continuous trace_valid.
- Reset asserted mid-cycle clears registers and trace outputs without waiting for clk; a write in flight on that cycle is discarded and not traced.
- Reset release: first write is accepted on the first rising edge with reset=1.

## Structure

- Shared package: REG_ZERO = 0, REG_RA = 31, DATA_W/ADDR_W defaults, shared with the write-back selection logic that drives $31 for link instructions.
- One sub-module natural: grf_read_port (address, storage array view, write-bypass inputs -> data), instantiated twice.
- Storage as a 2^ADDR_W-1 entry array (index 0 not stored); trace register block in the top.

## Test plan

- Reset: hold reset=0, drive ra1=5, ra2=31 -> rd1=rd2=0, trace_valid=0; release, no writes -> still 0.
- Basic write/read: we=1, wa=8, wd=0x12345678, wpc=0x00003000 -> next cycle rd1(ra1=8)=0x12345678; trace_valid=1, trace_pc=0x00003000, trace_addr=8, trace_data=0x12345678.
- $0 protection: we=1, wa=0, wd=0xFFFFFFFF -> rd1(ra1=0)=0 same and next cycle; trace_valid=1, trace_addr=0, trace_data=0.
- Bypass: reg 9 = 1, same cycle we=1, wa=9, wd=7, ra1=ra2=9 -> BYPASS=1: rd1=rd2=7 before edge; BYPASS=0: rd1=rd2=1 before edge, 7 after.
- Link write: we=1, wa=31, wd=0x00003008 -> reg 31 = 0x00003008; back-to-back write to wa=2 next cycle -> trace_valid high two consecutive cycles with correct fields.
- Async reset mid-run: registers 1..31 loaded with nonzero values, pull reset=0 between edges -> rd1/rd2 and all trace outputs 0 immediately, pending write not applied.

Source files
------------

// File: rtl/grf_pkg.sv
// Shared definitions for the general register file and the write-back
// selection logic that feeds it (link instructions target REG_RA).
package grf_pkg;

    localparam int GRF_DATA_W = 32;
    localparam int GRF_ADDR_W = 5;

    // Architectural register indices with fixed meaning
    localparam int REG_ZERO = 0;
    localparam int REG_RA   = 31;

    // Where a read port takes its value from in a given cycle
    typedef enum logic [1:0] {
        SRC_ZERO   = 2'd0,
        SRC_BYPASS = 2'd1,
        SRC_STORE  = 2'd2
    } rd_src_e;

endpackage

// File: rtl/grf_if.sv
// Register-file bus: write-back port, two decode read ports and the
// write-trace record. The write-back/decode side uses master, the
// register file uses slave.
interface grf_if
    import grf_pkg::*;
#(
    parameter int DATA_W = GRF_DATA_W,
    parameter int ADDR_W = GRF_ADDR_W
);
    logic              we;
    logic [ADDR_W-1:0] wa;
    logic [DATA_W-1:0] wd;
    logic [31:0]       wpc;
    logic [ADDR_W-1:0] ra1;
    logic [ADDR_W-1:0] ra2;
    logic [DATA_W-1:0] rd1;
    logic [DATA_W-1:0] rd2;
    logic              trace_valid;
    logic [31:0]       trace_pc;
    logic [ADDR_W-1:0] trace_addr;
    logic [DATA_W-1:0] trace_data;

    modport master (
        output we, wa, wd, wpc, ra1, ra2,
        input  rd1, rd2, trace_valid, trace_pc, trace_addr, trace_data
    );

    modport slave (
        input  we, wa, wd, wpc, ra1, ra2,
        output rd1, rd2, trace_valid, trace_pc, trace_addr, trace_data
    );
endinterface

// File: rtl/grf_read_port.sv
// One combinational read port: $0 and reset force zero, an in-flight
// write to the same index is forwarded when BYPASS is enabled, otherwise
// the stored value is returned.
module grf_read_port
    import grf_pkg::*;
#(
    parameter int DATA_W = GRF_DATA_W,
    parameter int ADDR_W = GRF_ADDR_W,
    parameter int BYPASS = 1
) (
    input  logic              i_en,
    input  logic [ADDR_W-1:0] i_ra,
    input  logic [DATA_W-1:0] i_regs [1:(1<<ADDR_W)-1],
    input  logic              i_we,
    input  logic [ADDR_W-1:0] i_wa,
    input  logic [DATA_W-1:0] i_wd,
    output logic [DATA_W-1:0] o_rd
);

    rd_src_e w_src;

    // Pick the data source; reset and $0 take priority over the bypass
    always_comb begin
        w_src = SRC_STORE;
        if (!i_en || (i_ra == ADDR_W'(REG_ZERO))) begin
            w_src = SRC_ZERO;
        end else if ((BYPASS != 0) && i_we && (i_wa == i_ra)) begin
            w_src = SRC_BYPASS;
        end
    end

    // Drive the read data from the selected source
    always_comb begin
        o_rd = '0;
        case (w_src)
            SRC_BYPASS: o_rd = i_wd;
            SRC_STORE:  o_rd = i_regs[i_ra];
            default:    o_rd = '0;
        endcase
    end

endmodule

// File: rtl/grf.sv
// General register file for the single-cycle MIPS datapath: 31 writable
// registers plus hardwired $0, two combinational read ports and a
// one-cycle registered trace record of every write-enabled cycle.
module grf
    import grf_pkg::*;
#(
    parameter int DATA_W = GRF_DATA_W,
    parameter int ADDR_W = GRF_ADDR_W,
    parameter int BYPASS = 1
) (
    input  logic  clk,
    input  logic  reset,
    grf_if.slave  bus
);

    localparam int NREG = 1 << ADDR_W;

    // Storage starts at index 1; $0 has no flops behind it
    logic [DATA_W-1:0] r_regs [1:NREG-1];

    logic              w_wr_acc;
    logic [DATA_W-1:0] w_trace_data;
    logic [DATA_W-1:0] w_rd1;
    logic [DATA_W-1:0] w_rd2;

    logic              r_trace_vld_p1;
    logic [31:0]       r_trace_pc_p1;
    logic [ADDR_W-1:0] r_trace_addr_p1;
    logic [DATA_W-1:0] r_trace_data_p1;

    assign w_wr_acc     = bus.we && (bus.wa != ADDR_W'(REG_ZERO));
    assign w_trace_data = (bus.wa == ADDR_W'(REG_ZERO)) ? '0 : bus.wd;

    // Register array update; reset clears every stored register at once
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 1; i < NREG; i++) begin
                r_regs[i] <= '0;
            end
        end else if (w_wr_acc) begin
            r_regs[bus.wa] <= bus.wd;
        end
    end

    // ---- stage p0 -> p1: trace record of the write accepted on this edge
    // Fields only load on write-enabled cycles so they hold between writes
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_trace_vld_p1  <= 1'b0;
            r_trace_pc_p1   <= '0;
            r_trace_addr_p1 <= '0;
            r_trace_data_p1 <= '0;
        end else begin
            r_trace_vld_p1 <= bus.we;
            if (bus.we) begin
                r_trace_pc_p1   <= bus.wpc;
                r_trace_addr_p1 <= bus.wa;
                r_trace_data_p1 <= w_trace_data;
            end
        end
    end

    grf_read_port #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W),
        .BYPASS (BYPASS)
    ) u_rp1 (
        .i_en   (reset),
        .i_ra   (bus.ra1),
        .i_regs (r_regs),
        .i_we   (bus.we),
        .i_wa   (bus.wa),
        .i_wd   (bus.wd),
        .o_rd   (w_rd1)
    );

    grf_read_port #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W),
        .BYPASS (BYPASS)
    ) u_rp2 (
        .i_en   (reset),
        .i_ra   (bus.ra2),
        .i_regs (r_regs),
        .i_we   (bus.we),
        .i_wa   (bus.wa),
        .i_wd   (bus.wd),
        .o_rd   (w_rd2)
    );

    assign bus.rd1         = w_rd1;
    assign bus.rd2         = w_rd2;
    assign bus.trace_valid = r_trace_vld_p1;
    assign bus.trace_pc    = r_trace_pc_p1;
    assign bus.trace_addr  = r_trace_addr_p1;
    assign bus.trace_data  = r_trace_data_p1;

endmodule
